// File: rtl/seq_divider.sv
// Multi-cycle restoring divider (RV64M DIV/DIVU/REM/REMU) with its 64-bit add_sub trial subtractor.
// Optional DIV_EARLY_OUT_EN: divide-by-zero and signed overflow skip CALC/FIX and finish directly.
module add_sub #(
  parameter int unsigned W = 64
) (
  input  logic [W-1:0] in1,
  input  logic [W-1:0] in2,
  input  logic         sub,
  output logic [W-1:0] sum_out,
  output logic         carry_out
);
  logic [W-1:0] b;
  logic [W:0]   c;

  always_comb begin
    b    = sub ? ~in2 : in2;
    c    = '0;
    c[0] = sub;
    sum_out = '0;
    for (int unsigned i = 0; i < W; i++) begin
      sum_out[i] = in1[i] ^ b[i] ^ c[i];
      c[i+1]     = (in1[i] & b[i]) | (in1[i] & c[i]) | (b[i] & c[i]);
    end
    carry_out = c[W];
  end
endmodule

module seq_divider #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned CNT_W = 7
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            is_signed,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder,
  output logic            div_by_zero
);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  localparam logic [XLEN-1:0]  MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(XLEN - 1);

  state_t          state;
  logic [XLEN-1:0] q_sh;
  logic [XLEN-1:0] r_part;
  logic [XLEN-1:0] dvsr_mag;
  logic [XLEN-1:0] dvd_orig;
  logic            neg_q;
  logic            neg_r;
  logic            dz;
  logic            ovf;
  logic [CNT_W-1:0] count;

  logic            in_dvd_neg;
  logic            in_dvsr_neg;
  logic [XLEN-1:0] in_dvd_mag;
  logic [XLEN-1:0] in_dvsr_mag;
  logic            in_dz;
  logic            in_ovf;

  always_comb begin
    in_dvd_neg  = is_signed & dividend[XLEN-1];
    in_dvsr_neg = is_signed & divisor[XLEN-1];
    in_dvd_mag  = in_dvd_neg  ? (~dividend + 1'b1) : dividend;
    in_dvsr_mag = in_dvsr_neg ? (~divisor  + 1'b1) : divisor;
    in_dz       = (divisor == '0);
    in_ovf      = is_signed && (dividend == MIN_VAL) && (divisor == '1);
  end

  // Partial remainder shifted left with the next dividend bit pulled from the quotient shifter's MSB.
  logic [XLEN:0]   s_ext;
  logic [XLEN-1:0] diff;
  logic            no_borrow;
  logic            keep;

  assign s_ext = {r_part, q_sh[XLEN-1]};

  add_sub #(.W(XLEN)) u_add_sub (
    .in1       (s_ext[XLEN-1:0]),
    .in2       (dvsr_mag),
    .sub       (1'b1),
    .sum_out   (diff),
    .carry_out (no_borrow)
  );

  assign keep = s_ext[XLEN] | no_borrow;

  logic [XLEN-1:0] fix_q;
  logic [XLEN-1:0] fix_r;
  logic            fix_dz;

  always_comb begin
    fix_q  = neg_q ? (~q_sh   + 1'b1) : q_sh;
    fix_r  = neg_r ? (~r_part + 1'b1) : r_part;
    fix_dz = 1'b0;
    if (dz) begin
      fix_q  = '1;
      fix_r  = dvd_orig;
      fix_dz = 1'b1;
    end else if (ovf) begin
      fix_q = dvd_orig;
      fix_r = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      q_sh        <= '0;
      r_part      <= '0;
      dvsr_mag    <= '0;
      dvd_orig    <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dz          <= 1'b0;
      ovf         <= 1'b0;
      count       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dvd_orig <= dividend;
            dvsr_mag <= in_dvsr_mag;
            q_sh     <= in_dvd_mag;
            r_part   <= '0;
            count    <= '0;
            neg_q    <= in_dvd_neg ^ in_dvsr_neg;
            neg_r    <= in_dvd_neg;
            dz       <= in_dz;
            ovf      <= in_ovf;
            busy     <= 1'b1;
`ifdef DIV_EARLY_OUT_EN
            if (in_dz || in_ovf) begin
              quotient    <= in_dz ? '1 : dividend;
              remainder   <= in_dz ? dividend : '0;
              div_by_zero <= in_dz;
              done        <= 1'b1;
              state       <= DONE;
            end else begin
              state <= CALC;
            end
`else
            state <= CALC;
`endif
          end
        end
        CALC: begin
          q_sh   <= {q_sh[XLEN-2:0], keep};
          r_part <= keep ? diff : s_ext[XLEN-1:0];
          count  <= count + 1'b1;
          if (count == LAST) state <= FIX;
        end
        FIX: begin
          quotient    <= fix_q;
          remainder   <= fix_r;
          div_by_zero <= fix_dz;
          done        <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_seq_divider.sv
// Directed vector bench for seq_divider; expected latencies follow DIV_EARLY_OUT_EN when defined.
module tb_seq_divider;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        is_signed;
  logic [63:0] dividend;
  logic [63:0] divisor;
  logic        busy;
  logic        done;
  logic [63:0] quotient;
  logic [63:0] remainder;
  logic        div_by_zero;

  always #5 clk = ~clk;

  seq_divider #(.XLEN(64), .CNT_W(7)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

`ifdef DIV_EARLY_OUT_EN
  localparam int SPECIAL_LAT = 1;
`else
  localparam int SPECIAL_LAT = 66;
`endif

  typedef struct {
    logic        sgn;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] q;
    logic [63:0] r;
    logic        dz;
    logic        special;
  } vec_t;

  vec_t vecs[13];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Latency is the index of the first falling edge where done is seen; edge 0 samples start.
  task automatic do_op(input logic sgn, input logic [63:0] a, input logic [63:0] b,
                       output int lat, output logic busy_at_done, output logic [63:0] q_hold);
    @(negedge clk);
    start = 1'b1; is_signed = sgn; dividend = a; divisor = b;
    lat = 0; busy_at_done = 1'b0; q_hold = '0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 1) q_hold = quotient;
      if (done) begin
        lat = c;
        busy_at_done = busy;
        break;
      end
    end
  endtask

  initial begin
    int          lat;
    int          exp_lat;
    logic        bsy;
    logic [63:0] qh;
    logic [63:0] prev_q;
    logic        seen_done;

    vecs[0]  = '{1'b0, 64'd100, 64'd7, 64'd14, 64'd2, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 1'b1, 1'b1};
    vecs[3]  = '{1'b1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'd0, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 64'd1, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 64'd0, 64'd5, 64'd0, 64'd0, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFB, 1'b1, 1'b1};
    vecs[9]  = '{1'b0, 64'h8000_0000_0000_0000, 64'd3, 64'h2AAA_AAAA_AAAA_AAAA, 64'd2, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 64'h8000_0000_0000_0000, 64'd1, 64'h8000_0000_0000_0000, 64'd0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'h8000_0000_0000_0000, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 64'd12345, 64'd1, 64'd12345, 64'd0, 1'b0, 1'b0};

    rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
    #12;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_q", quotient, 64'd0);
    chk("rst_r", remainder, 64'd0);
    chk("rst_dz", {63'd0, div_by_zero}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    prev_q = '0;
    for (int i = 0; i < 13; i++) begin
      exp_lat = vecs[i].special ? SPECIAL_LAT : 66;
      do_op(vecs[i].sgn, vecs[i].a, vecs[i].b, lat, bsy, qh);
      chk($sformatf("v%0d_latency", i), 64'(lat), 64'(exp_lat));
      chk($sformatf("v%0d_q", i), quotient, vecs[i].q);
      chk($sformatf("v%0d_r", i), remainder, vecs[i].r);
      chk($sformatf("v%0d_dz", i), {63'd0, div_by_zero}, {63'd0, vecs[i].dz});
      chk($sformatf("v%0d_busy_at_done", i), {63'd0, bsy}, 64'd1);
      if (exp_lat == 66) chk($sformatf("v%0d_q_held", i), qh, prev_q);
      @(negedge clk);
      chk($sformatf("v%0d_busy_after", i), {63'd0, busy}, 64'd0);
      chk($sformatf("v%0d_done_pulse", i), {63'd0, done}, 64'd0);
      chk($sformatf("v%0d_q_hold", i), quotient, vecs[i].q);
      prev_q = vecs[i].q;
    end

    // Ignored second start while busy, then abort by reset mid-CALC.
    seen_done = 1'b0;
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0; dividend = 64'd100; divisor = 64'd7;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) seen_done = 1'b1;
      if (c == 10) begin
        start = 1'b1; dividend = 64'd9; divisor = 64'd3;
      end
      if (c == 30) rst_n = 1'b0;
    end
    #1;
    chk("abort_no_done", {63'd0, seen_done}, 64'd0);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_q", quotient, 64'd0);
    chk("abort_r", remainder, 64'd0);
    chk("abort_dz", {63'd0, div_by_zero}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(1'b0, 64'd9, 64'd3, lat, bsy, qh);
    chk("post_latency", 64'(lat), 64'd66);
    chk("post_q", quotient, 64'd3);
    chk("post_r", remainder, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
